la_ioanalog_arb: RTL and testbench

- Arbiter and sequencer for the analog passthrough pad: REQS core requesters share one analog pad and its three core taps.
- Taps: 0 = direct with ESD clamp, 1 = small series R, 2 = big series R.
- Drives one-hot analog switch enables with break-before-make and settle timing. A requester's grant asserts only after its tap has settled.
- Sits in the core beside the analog IO cell, between analog macros (ADC, DAC, monitors) and the switch fabric.

---
 rtl/la_ioanalog_arb.sv | 148 ++++++++++++++
 tb/tb_la_ioanalog_arb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/la_ioanalog_arb.sv
// Arbiter/sequencer for the shared analog passthrough pad: round-robin owner
// selection, one-hot tap switch enables with settle and break-before-make timing.
module la_ioanalog_arb #(
    parameter int REQS    = 4,
    parameter int SETTLE  = 4,
    parameter int BBM     = 2,
    parameter int MAXHOLD = 0
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [REQS-1:0]           req,
    input  logic [2*REQS-1:0]         tap,
    output logic [REQS-1:0]           gnt,
    output logic [2:0]                sw_en,
    output logic [$clog2(REQS)-1:0]   owner,
    output logic                      busy,
    output logic                      preempt,
    output logic                      err
);

    localparam int OW = $clog2(REQS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GRANT  = 2'd2,
        ST_BREAK  = 2'd3
    } state_t;

    state_t        state;
    logic [OW-1:0] ptr;
    logic [7:0]    cnt;
    logic [15:0]   hcnt;

    logic          win_found;
    logic [OW-1:0] win_idx;
    logic          scan_err;
    logic          other_valid;
    logic [OW-1:0] next_ptr;

    function automatic logic [2:0] tap_dec(input logic [1:0] t);
        return 3'b001 << t;
    endfunction

    // Round-robin scan from ptr; invalid-tap requesters passed before the winner flag err.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        scan_err  = 1'b0;
        for (int k = 0; k < REQS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= REQS) idx = idx - REQS;
            if (!win_found && req[idx]) begin
                if (tap[2*idx +: 2] == 2'd3) begin
                    scan_err = 1'b1;
                end else begin
                    win_found = 1'b1;
                    win_idx   = idx[OW-1:0];
                end
            end
        end
    end

    always_comb begin
        other_valid = 1'b0;
        for (int j = 0; j < REQS; j++) begin
            if (j != int'(owner) && req[j] && tap[2*j +: 2] != 2'd3) other_valid = 1'b1;
        end
    end

    assign next_ptr = (int'(owner) == REQS - 1) ? '0 : owner + OW'(1);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            hcnt    <= '0;
            gnt     <= '0;
            sw_en   <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
            err     <= 1'b0;
        end else begin
            preempt <= 1'b0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    err <= scan_err;
                    if (win_found) begin
                        state <= ST_SETTLE;
                        owner <= win_idx;
                        sw_en <= tap_dec(tap[2*win_idx +: 2]);
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!req[owner]) begin
                        state <= ST_BREAK;
                        sw_en <= '0;
                        cnt   <= '0;
                        ptr   <= next_ptr;
                    end else if (cnt == 8'(SETTLE - 1)) begin
                        state        <= ST_GRANT;
                        gnt          <= '0;
                        gnt[owner]   <= 1'b1;
                        hcnt         <= 16'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_GRANT: begin
                    // A release wins over a simultaneous preemption condition.
                    if (!req[owner]) begin
                        state <= ST_BREAK;
                        gnt   <= '0;
                        sw_en <= '0;
                        cnt   <= '0;
                        ptr   <= next_ptr;
                    end else if (MAXHOLD != 0 && hcnt >= 16'(MAXHOLD) && other_valid) begin
                        state   <= ST_BREAK;
                        gnt     <= '0;
                        sw_en   <= '0;
                        cnt     <= '0;
                        ptr     <= next_ptr;
                        preempt <= 1'b1;
                    end else if (hcnt != 16'hffff) begin
                        hcnt <= hcnt + 16'd1;
                    end
                end
                ST_BREAK: begin
                    if (cnt == 8'(BBM - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_la_ioanalog_arb.sv
// Bench for la_ioanalog_arb: vector table for single-request, abort and invalid-tap
// cases, plus sequences for round robin, preemption and reset mid-grant.
module tb_la_ioanalog_arb;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] tap = '0;

    logic [3:0] a_gnt, b_gnt;
    logic [2:0] a_sw, b_sw;
    logic [1:0] a_owner, b_owner;
    logic       a_busy, b_busy, a_pre, b_pre, a_err, b_err;

    int checks = 0;
    int errors = 0;
    int a_pre_n = 0;
    int b_pre_n = 0;

    always #5 clk = ~clk;

    la_ioanalog_arb #(.REQS(4), .SETTLE(4), .BBM(2), .MAXHOLD(8)) dut_a (
        .clk(clk), .nreset(nreset), .req(req), .tap(tap), .gnt(a_gnt), .sw_en(a_sw),
        .owner(a_owner), .busy(a_busy), .preempt(a_pre), .err(a_err)
    );

    la_ioanalog_arb #(.REQS(4), .SETTLE(4), .BBM(2), .MAXHOLD(0)) dut_b (
        .clk(clk), .nreset(nreset), .req(req), .tap(tap), .gnt(b_gnt), .sw_en(b_sw),
        .owner(b_owner), .busy(b_busy), .preempt(b_pre), .err(b_err)
    );

    always @(negedge clk) begin
        if (a_pre) a_pre_n++;
        if (b_pre) b_pre_n++;
    end

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [7:0] tap;
        logic [3:0] gnt;
        logic [2:0] sw;
        logic [1:0] own;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [7:0] tp,
                       input logic [3:0] g, input logic [2:0] s, input logic [1:0] o,
                       input logic b, input logic e);
        vec_t v;
        v.rst_n = r; v.req = rq; v.tap = tp; v.gnt = g; v.sw = s; v.own = o; v.busy = b; v.err = e;
        vt.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        int w, g, n, zc;
        logic [11:0] exp_v, act_v;

        // Single request on requester 1, tap 1
        add(0, 4'b0000, 8'h00, 4'b0000, 3'b000, 2'd0, 0, 0);
        repeat (4) add(1, 4'b0010, 8'h04, 4'b0000, 3'b010, 2'd1, 1, 0);
        repeat (2) add(1, 4'b0010, 8'h04, 4'b0010, 3'b010, 2'd1, 1, 0);
        repeat (2) add(1, 4'b0000, 8'h04, 4'b0000, 3'b000, 2'd1, 1, 0);
        add(1, 4'b0000, 8'h04, 4'b0000, 3'b000, 2'd1, 0, 0);
        // Abort during SETTLE on requester 2, tap 2
        add(0, 4'b0000, 8'h20, 4'b0000, 3'b000, 2'd0, 0, 0);
        repeat (3) add(1, 4'b0100, 8'h20, 4'b0000, 3'b100, 2'd2, 1, 0);
        repeat (2) add(1, 4'b0000, 8'h20, 4'b0000, 3'b000, 2'd2, 1, 0);
        add(1, 4'b0000, 8'h20, 4'b0000, 3'b000, 2'd2, 0, 0);
        // Invalid tap on requester 1, then requester 2 with tap 0
        add(0, 4'b0000, 8'h0C, 4'b0000, 3'b000, 2'd0, 0, 0);
        repeat (2) add(1, 4'b0010, 8'h0C, 4'b0000, 3'b000, 2'd0, 0, 1);
        add(1, 4'b0110, 8'h0C, 4'b0000, 3'b001, 2'd2, 1, 1);
        repeat (3) add(1, 4'b0110, 8'h0C, 4'b0000, 3'b001, 2'd2, 1, 0);
        repeat (2) add(1, 4'b0110, 8'h0C, 4'b0100, 3'b001, 2'd2, 1, 0);
        repeat (2) add(1, 4'b0010, 8'h0C, 4'b0000, 3'b000, 2'd2, 1, 0);
        add(1, 4'b0010, 8'h0C, 4'b0000, 3'b000, 2'd2, 0, 0);
        add(1, 4'b0010, 8'h0C, 4'b0000, 3'b000, 2'd2, 0, 1);

        foreach (vt[i]) begin
            nreset = vt[i].rst_n;
            req    = vt[i].req;
            tap    = vt[i].tap;
            step();
            exp_v = {vt[i].gnt, vt[i].sw, vt[i].own, vt[i].busy, 1'b0, vt[i].err};
            act_v = {a_gnt, a_sw, a_owner, a_busy, a_pre, a_err};
            chk($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
        end

        // Round robin, all requesters on tap 0
        nreset = 0; req = '0; tap = '0; step();
        nreset = 1; req = 4'b1111;
        zc = 0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (a_gnt == 4'b0000 && w < 30) begin
                step(); w++;
                if (a_sw == 3'b000) zc++;
            end
            chk($sformatf("rr_grant%0d", k), 32'(a_gnt), 32'(1) << (k % 4));
            if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(zc >= 3), 32'd1);
            repeat (3) step();
            req[k % 4] = 1'b0;
            step();
            zc = (a_sw == 3'b000) ? 1 : 0;
            req[k % 4] = 1'b1;
        end

        // Preemption with MAXHOLD=8 (dut_a) versus disabled (dut_b)
        nreset = 0; req = '0; tap = '0; step();
        a_pre_n = 0; b_pre_n = 0;
        nreset = 1; req = 4'b0001;
        w = 0;
        while (a_gnt == 4'b0000 && w < 20) begin step(); w++; end
        chk("pre_first_gnt", 32'(a_gnt), 32'h1);
        g = 1;
        step(); if (a_gnt == 4'b0001) g++;
        step(); if (a_gnt == 4'b0001) g++;
        req = 4'b1001;
        w = 0;
        while (w < 20) begin
            step(); w++;
            if (a_gnt == 4'b0001) g++;
            else break;
        end
        chk("pre_pulse", 32'(a_pre), 32'd1);
        chk("pre_hold_len", 32'(g), 32'd8);
        n = 0;
        while (a_gnt == 4'b0000 && n < 20) begin step(); n++; end
        chk("pre_next_gnt", 32'(a_gnt), 32'h8);
        chk("pre_next_lat", 32'(n), 32'd7);
        chk("pre_count", 32'(a_pre_n), 32'd1);
        chk("nopre_gnt", 32'(b_gnt), 32'h1);
        chk("nopre_count", 32'(b_pre_n), 32'd0);

        // Reset while dut_a grants requester 3 and requester 0 keeps requesting
        nreset = 0; step();
        chk("rst_a_outs", 32'({a_gnt, a_sw, a_owner, a_busy, a_pre, a_err}), 32'd0);
        chk("rst_b_outs", 32'({b_gnt, b_sw, b_owner, b_busy, b_pre, b_err}), 32'd0);
        nreset = 1; step();
        chk("rst_resettle", 32'({a_gnt, a_sw, a_owner, a_busy}), 32'({4'b0000, 3'b001, 2'd0, 1'b1}));
        repeat (3) step();
        chk("rst_no_gnt_yet", 32'(a_gnt), 32'h0);
        step();
        chk("rst_gnt0", 32'(a_gnt), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
